usb_data_buffer: RTL and testbench

- 64-byte shared FIFO between the AHB-Lite slave (host side) and the USB RX/TX packet engines (bus side).
- Stores RX packet payload for AHB reads and AHB-written data for TX packets.
- Produces `buffer_occupancy`, which the protocol controller consumes to drive `rx_data_ready`, `d_mode` and TX length decisions.
- Honors the controller's `clear` pulse.
- Half-duplex: only one direction is in use at a time, but simultaneous one-side write plus other-side read is legal.

---
 rtl/usb_pkg.sv | 24 ++
 rtl/usb_fifo_ctrl.sv | 111 +++++++++++
 rtl/usb_data_buffer.sv | 100 ++++++++++
 tb/tb_usb_data_buffer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// usb_pkg: shared constants, transfer-size encoding and helpers for the USB data path.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package usb_pkg;

  localparam int BUFFER_DEPTH = 64;
  localparam int OCC_W        = 7;

  // AHB transfer size; encoding 2'd3 is reserved and handled as a word.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  function automatic logic [2:0] size_to_bytes(input size_t sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/usb_fifo_ctrl.sv
// usb_fifo_ctrl: pointer/count bookkeeping and push/pop arbitration for the USB data buffer.
// Latency: pointers and count update on the clock edge of the accepted strobe.
// Backpressure: none; a push that does not fit or a pop that is short is dropped whole.
// Ports: clk/n_rst; clr (clear|flush); ahb_push/usb_push, ahb_pop/usb_pop strobes;
//        ahb_n (AHB byte count 1/2/4); wptr/rptr/count state; wr_ahb/wr_usb write enables;
//        err (sticky drop flag, only when USB_DATA_BUFFER_ERR_FLAG_EN is defined).
module usb_fifo_ctrl
  import usb_pkg::*;
#(
  parameter  int DEPTH = BUFFER_DEPTH,
  parameter  int OCC_W = usb_pkg::OCC_W,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clr,
  input  logic             ahb_push,
  input  logic             usb_push,
  input  logic             ahb_pop,
  input  logic             usb_pop,
  input  logic [2:0]       ahb_n,
  output logic [PTR_W-1:0] wptr,
  output logic [PTR_W-1:0] rptr,
  output logic [OCC_W-1:0] count,
  output logic             wr_ahb,
  output logic             wr_usb
`ifdef USB_DATA_BUFFER_ERR_FLAG_EN
  ,
  output logic             err
`endif
);

  // One extra bit so count + push can reach DEPTH + 4 without wrapping.
  localparam int EW = OCC_W + 1;

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [OCC_W-1:0] count_q, count_d;

  logic          push_req, pop_req;
  logic          push_ok, pop_ok;
  logic [2:0]    push_n, pop_n;
  logic [EW-1:0] popped, pushed, room;

  always_comb begin
    // AHB side wins both same-direction conflicts.
    pop_req  = ahb_pop | usb_pop;
    pop_n    = ahb_pop ? ahb_n : 3'd1;
    pop_ok   = pop_req && (EW'(count_q) >= EW'(pop_n));
    popped   = pop_ok ? EW'(pop_n) : '0;

    push_req = ahb_push | usb_push;
    push_n   = ahb_push ? ahb_n : 3'd1;
    // Space is judged after the same-cycle pop has been taken out.
    room     = EW'(count_q) - popped + EW'(push_n);
    push_ok  = push_req && (room <= EW'(DEPTH));
    pushed   = push_ok ? EW'(push_n) : '0;

    wr_ahb   = push_ok & ahb_push & ~clr;
    wr_usb   = push_ok & ~ahb_push & usb_push & ~clr;

    if (clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      wptr_d  = wptr_q + PTR_W'(pushed);
      rptr_d  = rptr_q + PTR_W'(popped);
      count_d = OCC_W'(EW'(count_q) - popped + pushed);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign wptr  = wptr_q;
  assign rptr  = rptr_q;
  assign count = count_q;

`ifdef USB_DATA_BUFFER_ERR_FLAG_EN
  logic err_q, err_d;

  always_comb begin
    if (clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q | (push_req & ~push_ok) | (pop_req & ~pop_ok);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: rtl/usb_data_buffer.sv
// usb_data_buffer: 64-byte FIFO shared by the AHB slave (1/2/4-byte access) and USB RX/TX engines (1 byte).
// Latency: pushed bytes and buffer_occupancy visible the cycle after the strobe; reads are fall-through peeks.
// Backpressure: none; overflowing pushes and underflowing pops are dropped whole.
// Ports: clk, n_rst (async, active low), clear/flush; store_tx_data/tx_data/get_rx_data/data_size/rx_data (AHB);
//        store_rx_packet_data/rx_packet_data/get_tx_packet_data/tx_packet_data (USB); buffer_occupancy.
// Option: define USB_DATA_BUFFER_ERR_FLAG_EN to add the sticky buffer_error output.
module usb_data_buffer
  import usb_pkg::*;
#(
  parameter  int DEPTH = BUFFER_DEPTH,
  parameter  int OCC_W = usb_pkg::OCC_W,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             flush,
  input  logic             store_tx_data,
  input  logic [31:0]      tx_data,
  input  logic             get_rx_data,
  input  logic [1:0]       data_size,
  output logic [31:0]      rx_data,
  input  logic             store_rx_packet_data,
  input  logic [7:0]       rx_packet_data,
  input  logic             get_tx_packet_data,
  output logic [7:0]       tx_packet_data,
  output logic [OCC_W-1:0] buffer_occupancy
`ifdef USB_DATA_BUFFER_ERR_FLAG_EN
  ,
  output logic             buffer_error
`endif
);

  logic [7:0]       mem_q [DEPTH];
  logic [2:0]       ahb_n;
  logic [PTR_W-1:0] wptr, rptr;
  logic [OCC_W-1:0] count;
  logic             wr_ahb, wr_usb;

  logic             wr_en   [4];
  logic [PTR_W-1:0] wr_addr [4];
  logic [7:0]       wr_dat  [4];

  assign ahb_n = size_to_bytes(size_t'(data_size));

  usb_fifo_ctrl #(
    .DEPTH (DEPTH),
    .OCC_W (OCC_W)
  ) u_ctrl (
    .clk      (clk),
    .n_rst    (n_rst),
    .clr      (clear | flush),
    .ahb_push (store_tx_data),
    .usb_push (store_rx_packet_data),
    .ahb_pop  (get_rx_data),
    .usb_pop  (get_tx_packet_data),
    .ahb_n    (ahb_n),
    .wptr     (wptr),
    .rptr     (rptr),
    .count    (count),
    .wr_ahb   (wr_ahb),
    .wr_usb   (wr_usb)
`ifdef USB_DATA_BUFFER_ERR_FLAG_EN
    ,
    .err      (buffer_error)
`endif
  );

  // Up to four byte lanes written per cycle at consecutive (wrapping) addresses.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      wr_en[k]   = (wr_ahb && (3'(k) < ahb_n)) || (wr_usb && (k == 0));
      wr_addr[k] = wptr + PTR_W'(k);
      wr_dat[k]  = wr_ahb ? tx_data[8*k +: 8] : rx_packet_data;
    end
  end

  // Storage contents are don't-care after reset, so no reset on the array.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wr_en[k]) begin
        mem_q[wr_addr[k]] <= wr_dat[k];
      end
    end
  end

  // Lanes beyond the requested size or beyond the stored bytes read as zero.
  always_comb begin
    rx_data = '0;
    for (int k = 0; k < 4; k++) begin
      if ((3'(k) < ahb_n) && (OCC_W'(k) < count)) begin
        rx_data[8*k +: 8] = mem_q[rptr + PTR_W'(k)];
      end
    end
  end

  assign tx_packet_data   = (count != '0) ? mem_q[rptr] : 8'h00;
  assign buffer_occupancy = count;

endmodule

// File: tb/tb_usb_data_buffer.sv
module tb_usb_data_buffer;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        clear, flush;
  logic        store_tx_data;
  logic [31:0] tx_data;
  logic        get_rx_data;
  logic [1:0]  data_size;
  logic [31:0] rx_data;
  logic        store_rx_packet_data;
  logic [7:0]  rx_packet_data;
  logic        get_tx_packet_data;
  logic [7:0]  tx_packet_data;
  logic [6:0]  buffer_occupancy;
`ifdef USB_DATA_BUFFER_ERR_FLAG_EN
  logic        buffer_error;
`endif

  always #5 clk = ~clk;

  usb_data_buffer dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .clear                (clear),
    .flush                (flush),
    .store_tx_data        (store_tx_data),
    .tx_data              (tx_data),
    .get_rx_data          (get_rx_data),
    .data_size            (data_size),
    .rx_data              (rx_data),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data),
    .get_tx_packet_data   (get_tx_packet_data),
    .tx_packet_data       (tx_packet_data),
    .buffer_occupancy     (buffer_occupancy)
`ifdef USB_DATA_BUFFER_ERR_FLAG_EN
    ,
    .buffer_error         (buffer_error)
`endif
  );

  // Scoreboard: bytes in FIFO order; head is the next byte the DUT should present.
  logic [7:0] q[$];
  bit         err_m;
  int         n_cmp  = 0;
  int         n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] exp_rx(input int n);
    logic [31:0] r = '0;
    for (int k = 0; k < n; k++) begin
      if (k < q.size()) r[8*k +: 8] = q[k];
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_head();
    return (q.size() > 0) ? {24'h0, q[0]} : 32'h0;
  endfunction

  task automatic idle_inputs();
    clear = 0; flush = 0; store_tx_data = 0; tx_data = '0; get_rx_data = 0;
    data_size = 2'd0; store_rx_packet_data = 0; rx_packet_data = '0; get_tx_packet_data = 0;
  endtask

  task automatic post_checks(input string tag);
    check({tag, ":occ"}, 32'(buffer_occupancy), 32'(q.size()));
    check({tag, ":tx_head"}, {24'h0, tx_packet_data}, exp_head());
`ifdef USB_DATA_BUFFER_ERR_FLAG_EN
    check({tag, ":err"}, {31'h0, buffer_error}, {31'h0, err_m});
`endif
  endtask

  // One clock of stimulus: drive, check peeks, update the model, clock, check state.
  task automatic step(input string tag, input bit aw, input logic [31:0] wd, input bit uw,
                      input logic [7:0] ub, input bit ar, input bit ur,
                      input logic [1:0] sz, input bit clr);
    int n;
    store_tx_data = aw; tx_data = wd; store_rx_packet_data = uw; rx_packet_data = ub;
    get_rx_data = ar; get_tx_packet_data = ur; data_size = sz; clear = clr;
    #1;
    if (ar) check({tag, ":rx_data"}, rx_data, exp_rx(nbytes(sz)));
    if (ur) check({tag, ":tx_pk"}, {24'h0, tx_packet_data}, exp_head());
    if (clr) begin
      q.delete();
      err_m = 0;
    end else begin
      if (ar || ur) begin
        n = ar ? nbytes(sz) : 1;
        if (q.size() >= n) begin
          for (int i = 0; i < n; i++) void'(q.pop_front());
        end else err_m = 1;
      end
      if (aw || uw) begin
        n = aw ? nbytes(sz) : 1;
        if (q.size() + n <= 64) begin
          for (int i = 0; i < n; i++) q.push_back(aw ? wd[8*i +: 8] : ub);
        end else err_m = 1;
      end
    end
    @(posedge clk); #1;
    idle_inputs();
    post_checks(tag);
  endtask

  task automatic do_flush(input string tag);
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    q.delete();
    err_m = 0;
    post_checks(tag);
  endtask

  initial begin
    idle_inputs();
    err_m = 0;
    n_rst = 0;
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1;
    post_checks("reset_idle");

    // Put data in, then pull reset mid-cycle with strobes active.
    step("pre_rst0", 0, 0, 1, 8'hAA, 0, 0, 2'd0, 0);
    step("pre_rst1", 0, 0, 1, 8'hBB, 0, 0, 2'd0, 0);
    store_rx_packet_data = 1; store_tx_data = 1; get_rx_data = 1; data_size = 2'd2;
    #2;
    n_rst = 0;
    #1;
    check("rst_async:occ", 32'(buffer_occupancy), 32'd0);
    check("rst_async:rx_data", rx_data, 32'd0);
    check("rst_async:tx_pk", {24'h0, tx_packet_data}, 32'd0);
    @(posedge clk); #1;
    check("rst_hold:occ", 32'(buffer_occupancy), 32'd0);
    idle_inputs();
    n_rst = 1;
    q.delete();
    err_m = 0;

    // USB fill, AHB drain.
    for (int i = 1; i <= 8; i++) step("usb_fill", 0, 0, 1, 8'(i), 0, 0, 2'd0, 0);
    check("usb_fill:occ8", 32'(buffer_occupancy), 32'd8);
    step("ahb_pop_h0", 0, 0, 0, 0, 1, 0, 2'd1, 0);
    check("ahb_pop_h0:occ6", 32'(buffer_occupancy), 32'd6);
    step("ahb_pop_h1", 0, 0, 0, 0, 1, 0, 2'd1, 0);
    step("ahb_pop_w", 0, 0, 0, 0, 1, 0, 2'd2, 0);

    // Advance pointers to 62, then an AHB word that wraps the array.
    do_flush("flush_wrap");
    for (int i = 0; i < 62; i++) begin
      step("adv_push", 0, 0, 1, 8'(i + 8'h80), 0, 0, 2'd0, 0);
      step("adv_pop", 0, 0, 0, 0, 0, 1, 2'd0, 0);
    end
    step("wrap_push", 1, 32'hDDCC_BBAA, 0, 0, 0, 0, 2'd2, 0);
    data_size = 2'd2;
    #1;
    check("wrap_peek", rx_data, 32'hDDCC_BBAA);
    data_size = 2'd0;
    for (int i = 0; i < 4; i++) step("wrap_usb_pop", 0, 0, 0, 0, 0, 1, 2'd0, 0);
    check("wrap_done:occ", 32'(buffer_occupancy), 32'd0);

    // Full boundary.
    do_flush("flush_full");
    for (int i = 0; i < 64; i++) step("fill64", 0, 0, 1, 8'(i * 3), 0, 0, 2'd0, 0);
    step("overflow1", 0, 0, 1, 8'hF0, 0, 0, 2'd0, 0);
    check("overflow1:occ64", 32'(buffer_occupancy), 32'd64);
    step("full_swap", 1, 32'h0000_00EE, 0, 0, 0, 1, 2'd0, 0);
    check("full_swap:occ64", 32'(buffer_occupancy), 32'd64);
    step("to63", 0, 0, 0, 0, 0, 1, 2'd0, 0);
    step("push4_at63", 1, 32'h1234_5678, 0, 0, 0, 0, 2'd2, 0);
    check("push4_at63:occ63", 32'(buffer_occupancy), 32'd63);
    step("push_rsvd_at63", 1, 32'h9ABC_DEF0, 0, 0, 0, 0, 2'd3, 0);
    step("push2_at63", 1, 32'h0000_4321, 0, 0, 0, 0, 2'd1, 0);

    // Same-side conflicts: AHB wins.
    do_flush("flush_conf");
    step("conf_push", 1, 32'h0000_0011, 1, 8'h22, 0, 0, 2'd0, 0);
    check("conf_push:head", {24'h0, tx_packet_data}, 32'h11);
    step("conf_p1", 0, 0, 1, 8'h33, 0, 0, 2'd0, 0);
    step("conf_p2", 0, 0, 1, 8'h44, 0, 0, 2'd0, 0);
    step("conf_pop", 0, 0, 0, 0, 1, 1, 2'd1, 0);
    check("conf_pop:occ1", 32'(buffer_occupancy), 32'd1);

    // Empty boundary: short pop dropped, upper lanes zero.
    do_flush("flush_empty");
    step("one_byte", 0, 0, 1, 8'h5A, 0, 0, 2'd0, 0);
    data_size = 2'd1;
    #1;
    check("underflow:peek", rx_data, 32'h0000_005A);
    step("underflow", 0, 0, 0, 0, 1, 0, 2'd1, 0);
    check("underflow:occ1", 32'(buffer_occupancy), 32'd1);

    // Clear mid-packet overrides a same-cycle push.
    do_flush("flush_clr");
    for (int i = 0; i < 10; i++) step("clr_fill", 0, 0, 1, 8'(i + 8'h40), 0, 0, 2'd0, 0);
    step("clr_mid", 0, 0, 1, 8'h55, 0, 0, 2'd0, 1);
    check("clr_mid:occ0", 32'(buffer_occupancy), 32'd0);
    step("after_clr", 0, 0, 1, 8'h66, 0, 0, 2'd0, 0);
    check("after_clr:tx", {24'h0, tx_packet_data}, 32'h66);
    step("after_clr_pop", 0, 0, 0, 0, 1, 0, 2'd2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
